// File: rtl/iq_byte_sequencer_if.sv
// Byte-FIFO / I-FIFO / Q-FIFO handshake bundle for iq_byte_sequencer.
//   in_dout, in_empty : head byte and empty flag of the FWFT input byte FIFO
//   in_rd_en          : pop strobe into the input FIFO
//   i_din, i_wr_en    : I sample and push strobe into the I FIFO
//   q_din, q_wr_en    : Q sample and push strobe into the Q FIFO
//   i_full, q_full    : output FIFO full flags
// master = sequencer side, slave = FIFO side.
interface iq_byte_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] i_din;
    logic                  i_wr_en;
    logic                  i_full;
    logic [DATA_WIDTH-1:0] q_din;
    logic                  q_wr_en;
    logic                  q_full;

    modport master (
        input  in_dout, in_empty, i_full, q_full,
        output in_rd_en, i_din, i_wr_en, q_din, q_wr_en
    );

    modport slave (
        output in_dout, in_empty, i_full, q_full,
        input  in_rd_en, i_din, i_wr_en, q_din, q_wr_en
    );
endinterface

// File: rtl/iq_byte_sequencer.sv
// Pops raw bytes from the input byte FIFO, assembles each 4-byte group
// (I lo, I hi, Q lo, Q hi) into a signed 16-bit I/Q pair, quantizes both
// to DATA_WIDTH by a left shift of BITS, and pushes them in lockstep into
// the I and Q FIFOs. Sustains one byte per cycle.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-low
//   enable     : when low no pops and no pushes; partial state held
//   clear      : synchronous; drops partial pair, zeroes pair_count
//   fifo       : byte/I/Q FIFO handshake bundle (master side)
//   pair_count : I/Q pairs pushed since reset/clear (wraps silently)
//
// state | meaning
// S_B0  | awaiting I low byte
// S_B1  | awaiting I high byte
// S_B2  | awaiting Q low byte
// S_B3  | awaiting Q high byte
// S_WR  | pair complete, awaiting space in both output FIFOs
module iq_byte_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    iq_byte_sequencer_if.master fifo,
    output logic [31:0]         pair_count
);

    typedef enum logic [2:0] {
        S_B0,
        S_B1,
        S_B2,
        S_B3,
        S_WR
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  byte0, byte1, byte2, byte3;
    logic        rd_ok, wr_ok;
    logic        pop, push;

    logic [15:0]           i_raw, q_raw;
    logic [DATA_WIDTH-1:0] i_ext, q_ext;

    assign rd_ok = enable & ~clear & ~fifo.in_empty;
    assign wr_ok = enable & ~clear & ~fifo.i_full & ~fifo.q_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_B0;
        end else begin
            state <= state_nxt;
        end
    end

    // clear needs no explicit gating of pop/push: rd_ok and wr_ok already
    // include it, so only the next state has to be overridden.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        case (state)
            S_B0: if (rd_ok) begin pop = 1'b1; state_nxt = S_B1; end
            S_B1: if (rd_ok) begin pop = 1'b1; state_nxt = S_B2; end
            S_B2: if (rd_ok) begin pop = 1'b1; state_nxt = S_B3; end
            S_B3: if (rd_ok) begin pop = 1'b1; state_nxt = S_WR; end
            S_WR: begin
                if (wr_ok) begin
                    push = 1'b1;
                    // Overlap the first byte of the next pair with the push
                    // so the stream runs at one byte per cycle.
                    if (rd_ok) begin
                        pop       = 1'b1;
                        state_nxt = S_B1;
                    end else begin
                        state_nxt = S_B0;
                    end
                end
            end
            default: state_nxt = S_B0;
        endcase
        if (clear) begin
            state_nxt = S_B0;
        end
    end

    // Strobes are masked by reset so they drop the instant reset asserts,
    // not just once the state register has been forced back to S_B0.
    assign fifo.in_rd_en = pop & reset;
    assign fifo.i_wr_en  = push & reset;
    assign fifo.q_wr_en  = push & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte0 <= 8'h00;
            byte1 <= 8'h00;
            byte2 <= 8'h00;
            byte3 <= 8'h00;
        end else if (pop) begin
            case (state)
                S_B0, S_WR: byte0 <= fifo.in_dout;
                S_B1:       byte1 <= fifo.in_dout;
                S_B2:       byte2 <= fifo.in_dout;
                S_B3:       byte3 <= fifo.in_dout;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pair_count <= 32'd0;
        end else if (clear) begin
            pair_count <= 32'd0;
        end else if (push) begin
            pair_count <= pair_count + 32'd1;
        end
    end

    assign i_raw = {byte1, byte0};
    assign q_raw = {byte3, byte2};
    assign i_ext = {{(DATA_WIDTH-16){i_raw[15]}}, i_raw};
    assign q_ext = {{(DATA_WIDTH-16){q_raw[15]}}, q_raw};

    assign fifo.i_din = i_ext << BITS;
    assign fifo.q_din = q_ext << BITS;

endmodule

// File: doc/iq_byte_sequencer.md
# iq_byte_sequencer

Control FSM that sequences the IQ front end: pops raw bytes from the input byte FIFO, assembles each 4-byte group (I low, I high, Q low, Q high) into a signed 16-bit I/Q pair, quantizes both to DATA_WIDTH fixed point, and pushes them in lockstep into the I and Q output FIFOs. It sits between the byte input FIFO and the I/Q FIFOs inside the IQ read top level, and is the only agent driving their read and write strobes. It sustains one byte per cycle, which is one I/Q pair per 4 cycles.

## Interface
- DATA_WIDTH, 32, width of I/Q output samples
- BITS, 10, quantization left shift applied to each 16-bit sample
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- enable  in  1  when low, no pops and no pushes; partial state held
- clear  in  1  synchronous; discards any partial pair, FSM to S_B0
- in_dout  in  8  input FIFO head byte (first-word-fall-through, valid when !in_empty)
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  pop input FIFO this cycle
- i_din  out  DATA_WIDTH  quantized I sample
- i_wr_en  out  1  push I FIFO
- i_full  in  1  I FIFO full
- q_din  out  DATA_WIDTH  quantized Q sample
- q_wr_en  out  1  push Q FIFO
- q_full  in  1  Q FIFO full
- pair_count  out  32  number of I/Q pairs pushed since reset/clear

## Operation
- States: S_B0, S_B1, S_B2, S_B3 (awaiting byte n), S_WR (pair complete, awaiting output space).
- Define rd_ok = enable & !clear & !in_empty; wr_ok = enable & !clear & !i_full & !q_full.
- S_B0..S_B2: if rd_ok, latch in_dout into byte register n, assert in_rd_en, advance to next state; else hold.
- S_B3: if rd_ok, latch Q high, assert in_rd_en, go to S_WR.
- S_WR: if wr_ok, assert i_wr_en and q_wr_en in the same cycle and increment pair_count. If rd_ok is also true in that cycle, latch byte 0 of the next pair, assert in_rd_en, and go to S_B1; otherwise go to S_B0. If !wr_ok, hold with no pop.
- I and Q are never pushed separately. Both strobes depend on both full flags.
- Arithmetic: raw = {hi, lo} read as signed 16-bit, sign-extended to DATA_WIDTH, shifted left by BITS, truncated to DATA_WIDTH. i_din and q_din are combinational from the byte registers and stable throughout S_WR.
- pair_count wraps from 0xFFFFFFFF to 0 with no flag.
- clear is highest priority. Next state is S_B0 and pair_count becomes 0. No pop or push occurs in a clear cycle; byte registers may keep stale data.

## Timing
- Reset (async assert) values:
  - state S_B0; byte registers 0; pair_count 0.
  - in_rd_en, i_wr_en, q_wr_en all 0; i_din and q_din 0.
- in_rd_en, i_wr_en and q_wr_en are combinational from state and the FIFO flags (same-cycle handshake). Each FIFO acts on the rising edge where its strobe is high.
- Latency: the push happens in the cycle after the edge that pops the 4th byte (S_WR entered).
- Steady state with input non-empty and outputs not full: in_rd_en held high continuously, and one push every 4 cycles (S_WR, S_B1, S_B2, S_B3 repeating).
- in_empty in the middle of a pair: stall in the current state with no spurious pop. Resume on the first cycle that in_empty is low.
- i_full or q_full in S_WR: stall and keep the pair; i_din and q_din do not change. Push on the first cycle both are clear.
- enable low during a simultaneous pop and push in S_WR: neither happens.
- Reset deasserted in mid-stream: the FSM starts at S_B0. Byte alignment is the upstream's responsibility.

## Test plan
- Bytes 34 12 FF FF, outputs empty -> one push with i_din=0x0048D000, q_din=0xFFFFFC00, pair_count=1, exactly 4 pops.
- Continuous stream of 262144 bytes from the reference vector file -> 65536 pushes matching the golden I/Q files. in_rd_en stays high with no gaps once the input FIFO is primed.
- Insert in_empty for 3 cycles after byte 2 -> FSM holds in S_B2 with no pop during the stall. Resulting pair is unchanged and pushed after resume.
- Hold q_full high for 5 cycles while in S_WR with i_full low -> neither i_wr_en nor q_wr_en is asserted and no pop occurs. Both strobes rise together when q_full drops.
- Assert clear after 2 bytes, then feed 00 80 FF 7F -> partial pair discarded, pair_count=0. Next push is i_din=0xFE000000, q_din=0x01FFFC00.
- Assert async reset in the middle of S_WR -> all outputs go to 0 immediately (before the next clock edge), with state S_B0 and pair_count=0.
